// File: rtl/sat_pkg.sv
// Shared types and sizing helpers for the DPLL assignment datapath.
// Used by the assignment stack and by the clause evaluators.
package sat_pkg;

   localparam int NUM_CLAUSES_DEF         = 16;
   localparam int NUM_VARS_PER_CLAUSE_DEF = 3;
   localparam int DEPTH_DEF               = 8;
   localparam int W_DEF = NUM_CLAUSES_DEF * NUM_VARS_PER_CLAUSE_DEF;

   typedef logic [W_DEF-1:0] clause_vec_t;

   // Bits needed to count 0..depth inclusive.
   function automatic int depth_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth entries.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/clause_stack_mem.sv
// Snapshot storage: DEPTH x W register array with one write port and one
// asynchronous read port. Contents are never reset.
module clause_stack_mem
   import sat_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = addr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/clause_assignment_stack.sv
// Live clause-assignment register with a snapshot stack for DPLL backtracking.
// Push saves the live vector, pop restores it; misuse raises sticky errors.
module clause_assignment_stack
   import sat_pkg::*;
#(
   parameter int NUM_CLAUSES         = NUM_CLAUSES_DEF,
   parameter int NUM_VARS_PER_CLAUSE = NUM_VARS_PER_CLAUSE_DEF,
   parameter int DEPTH               = DEPTH_DEF,
   parameter int W  = NUM_CLAUSES * NUM_VARS_PER_CLAUSE,
   parameter int DW = depth_width(DEPTH),
   parameter int AW = addr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_clauses,
   input  logic          push,
   input  logic          pop,
   input  logic          clear_err,
   output logic [W-1:0]  out_clauses,
   output logic          out_valid,
   output logic [DW-1:0] depth_count,
   output logic          full,
   output logic          empty,
   output logic          err_overflow,
   output logic          err_underflow,
   output logic          err_conflict
);

   logic          push_ok;
   logic          pop_ok;
   logic          new_overflow;
   logic          new_underflow;
   logic          new_conflict;
   logic [DW-1:0] top_idx;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic [W-1:0]  top_data;

   assign full  = (depth_count == DW'(DEPTH));
   assign empty = (depth_count == '0);

   // Simultaneous push and pop is treated purely as a conflict: neither acts.
   always_comb begin
      push_ok       = 1'b0;
      pop_ok        = 1'b0;
      new_overflow  = 1'b0;
      new_underflow = 1'b0;
      new_conflict  = 1'b0;
      if (push && pop) begin
         new_conflict = 1'b1;
      end else if (push) begin
         push_ok      = !full;
         new_overflow = full;
      end else if (pop) begin
         pop_ok        = !empty;
         new_underflow = empty;
      end
   end

   assign top_idx = depth_count - DW'(1);
   assign waddr   = depth_count[AW-1:0];
   assign raddr   = top_idx[AW-1:0];

   clause_stack_mem #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok && !rst),
      .waddr (waddr),
      .wdata (out_clauses),
      .raddr (raddr),
      .rdata (top_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_clauses <= '0;
         out_valid   <= 1'b0;
         depth_count <= '0;
      end else begin
         // Pop outranks a same-cycle load; push saves the pre-load value.
         if (pop_ok) begin
            out_clauses <= top_data;
            out_valid   <= 1'b1;
         end else if (in_valid) begin
            out_clauses <= in_clauses;
            out_valid   <= 1'b1;
         end
         if (push_ok) begin
            depth_count <= depth_count + DW'(1);
         end else if (pop_ok) begin
            depth_count <= top_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         err_conflict  <= 1'b0;
      end else begin
         err_overflow  <= (err_overflow  && !clear_err) || new_overflow;
         err_underflow <= (err_underflow && !clear_err) || new_underflow;
         err_conflict  <= (err_conflict  && !clear_err) || new_conflict;
      end
   end

endmodule
